// File: rtl/wb_port_scheduler.sv
// Register-file write-port arbiter: the in-order WB stage has priority, and two multi-cycle units share the idle slots round-robin.
// A unit that waits STARVE_LIMIT cycles forces a DRAIN episode, which holds no_collision low until every starved unit has retired.
module wb_port_scheduler #(
  parameter int n            = 32,
  parameter int STARVE_LIMIT = 8,
  parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           pipe_wb_valid,
  input  logic [4:0]     pipe_wb_rd,
  input  logic [n-1:0]   pipe_wb_data,
  input  logic           pipe_wb_fp,
  input  logic [1:0]     mc_req_valid,
  input  logic [9:0]     mc_req_rd,
  input  logic [2*n-1:0] mc_req_data,
  input  logic [1:0]     mc_req_fp,
  output logic [1:0]     mc_req_ready,
  output logic           wb_we,
  output logic [4:0]     wb_rd,
  output logic [n-1:0]   wb_data,
  output logic           wb_fp,
  output logic           no_collision,
  output logic [15:0]    stall_cycles
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;

  state_t        state_reg, state_next;
  logic          rr_ptr_reg, rr_ptr_next;
  logic [15:0]   stall_cycles_reg, stall_cycles_next;
  logic [1:0]    starved;
  logic [1:0]    starved_next;
  logic [1:0]    pool;
  logic [1:0]    grant;
  logic [4:0]    unit_rd   [2];
  logic [n-1:0]  unit_data [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unit
      logic [CNT_W-1:0] wait_cnt_reg, wait_cnt_next;

      assign unit_rd[gi]   = mc_req_rd[gi*5 +: 5];
      assign unit_data[gi] = mc_req_data[gi*n +: n];

      // A unit is starved once its wait counter has saturated at the limit.
      assign starved[gi]      = (wait_cnt_reg == CNT_W'(STARVE_LIMIT));
      assign starved_next[gi] = (wait_cnt_next == CNT_W'(STARVE_LIMIT));

      always_comb begin
        if (!mc_req_valid[gi] || grant[gi]) begin
          wait_cnt_next = '0;
        end else if (starved[gi]) begin
          wait_cnt_next = wait_cnt_reg;
        end else begin
          wait_cnt_next = wait_cnt_reg + CNT_W'(1);
        end
      end

      always_ff @(posedge clk) begin
        if (!reset_n) begin
          wait_cnt_reg <= '0;
        end else begin
          wait_cnt_reg <= wait_cnt_next;
        end
      end
    end
  endgenerate

  // During DRAIN the starved units form the candidate pool; otherwise every valid unit does.
  always_comb begin
    pool  = '0;
    grant = '0;
    if (reset_n && !pipe_wb_valid) begin
      pool = mc_req_valid;
      if (state_reg == DRAIN && |(mc_req_valid & starved)) begin
        pool = mc_req_valid & starved;
      end
      case (pool)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_ptr_reg ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN: begin
        if (|(mc_req_valid & ~grant & starved)) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!(|starved_next)) begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    rr_ptr_next = rr_ptr_reg;
    if (grant[0]) begin
      rr_ptr_next = 1'b1;
    end else if (grant[1]) begin
      rr_ptr_next = 1'b0;
    end
  end

  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    if (state_reg == DRAIN && stall_cycles_reg != 16'hFFFF) begin
      stall_cycles_next = stall_cycles_reg + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg        <= RUN;
      rr_ptr_reg       <= 1'b0;
      stall_cycles_reg <= 16'd0;
    end else begin
      state_reg        <= state_next;
      rr_ptr_reg       <= rr_ptr_next;
      stall_cycles_reg <= stall_cycles_next;
    end
  end

  always_comb begin
    wb_we   = 1'b0;
    wb_rd   = '0;
    wb_data = '0;
    wb_fp   = 1'b0;
    if (reset_n) begin
      if (pipe_wb_valid) begin
        wb_we   = 1'b1;
        wb_rd   = pipe_wb_rd;
        wb_data = pipe_wb_data;
        wb_fp   = pipe_wb_fp;
      end else if (grant[0]) begin
        wb_we   = 1'b1;
        wb_rd   = unit_rd[0];
        wb_data = unit_data[0];
        wb_fp   = mc_req_fp[0];
      end else if (grant[1]) begin
        wb_we   = 1'b1;
        wb_rd   = unit_rd[1];
        wb_data = unit_data[1];
        wb_fp   = mc_req_fp[1];
      end
    end
  end

  assign mc_req_ready = grant;
  assign no_collision = !reset_n || (state_reg == RUN);
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler: a cycle-level behavioural model checked on every cycle,
// plus hand-computed expectations for reset, idle-slot grant, round-robin, starvation and reset during DRAIN.
module tb_wb_port_scheduler;
  localparam int N     = 32;
  localparam int LIMIT = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          pipe_wb_valid;
  logic [4:0]    pipe_wb_rd;
  logic [N-1:0]  pipe_wb_data;
  logic          pipe_wb_fp;
  logic [1:0]    mc_req_valid;
  logic [9:0]    mc_req_rd;
  logic [2*N-1:0] mc_req_data;
  logic [1:0]    mc_req_fp;
  logic [1:0]    mc_req_ready;
  logic          wb_we;
  logic [4:0]    wb_rd;
  logic [N-1:0]  wb_data;
  logic          wb_fp;
  logic          no_collision;
  logic [15:0]   stall_cycles;

  wb_port_scheduler #(.n(N), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .pipe_wb_valid(pipe_wb_valid), .pipe_wb_rd(pipe_wb_rd),
    .pipe_wb_data(pipe_wb_data), .pipe_wb_fp(pipe_wb_fp),
    .mc_req_valid(mc_req_valid), .mc_req_rd(mc_req_rd),
    .mc_req_data(mc_req_data), .mc_req_fp(mc_req_fp),
    .mc_req_ready(mc_req_ready), .wb_we(wb_we), .wb_rd(wb_rd),
    .wb_data(wb_data), .wb_fp(wb_fp),
    .no_collision(no_collision), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
  endtask

  // Behavioural model: how long each unit has been passed over, whether a stall episode is on.
  int  m_wait [2] = '{0, 0};
  bit  m_drain = 0;
  bit  m_rr = 0;
  int  m_stall = 0;
  int  n_wait [2] = '{0, 0};
  bit  n_drain = 0;
  bit  n_rr = 0;
  int  n_stall = 0;

  logic [1:0]   eg, cand, hungry;
  logic         e_we, e_fp, e_nc;
  logic [4:0]   e_rd;
  logic [N-1:0] e_data;

  always @(negedge clk) begin
    eg = 2'b00; e_we = 1'b0; e_rd = '0; e_data = '0; e_fp = 1'b0;
    if (!reset_n) begin
      e_nc = 1'b1;
      n_wait[0] = 0; n_wait[1] = 0; n_drain = 0; n_rr = 0; n_stall = 0;
    end else begin
      e_nc = !m_drain;
      if (!pipe_wb_valid) begin
        cand = mc_req_valid;
        hungry = 2'b00;
        for (int i = 0; i < 2; i++)
          if (mc_req_valid[i] && m_wait[i] == LIMIT) hungry[i] = 1'b1;
        if (m_drain && hungry != 2'b00) cand = hungry;
        if (cand == 2'b11) eg[m_rr] = 1'b1;
        else eg = cand;
      end
      if (pipe_wb_valid) begin
        e_we = 1'b1; e_rd = pipe_wb_rd; e_data = pipe_wb_data; e_fp = pipe_wb_fp;
      end else begin
        for (int i = 0; i < 2; i++)
          if (eg[i]) begin
            e_we = 1'b1; e_rd = mc_req_rd[i*5 +: 5]; e_data = mc_req_data[i*N +: N]; e_fp = mc_req_fp[i];
          end
      end
      for (int i = 0; i < 2; i++)
        n_wait[i] = (!mc_req_valid[i] || eg[i]) ? 0 : ((m_wait[i] + 1 > LIMIT) ? LIMIT : m_wait[i] + 1);
      if (!m_drain) begin
        n_drain = 0;
        for (int i = 0; i < 2; i++)
          if (mc_req_valid[i] && !eg[i] && m_wait[i] == LIMIT) n_drain = 1;
      end else begin
        n_drain = (n_wait[0] == LIMIT) || (n_wait[1] == LIMIT);
      end
      n_stall = m_drain ? ((m_stall == 65535) ? 65535 : m_stall + 1) : m_stall;
      n_rr = eg[0] ? 1'b1 : (eg[1] ? 1'b0 : m_rr);
    end
    check("model_ready", mc_req_ready, eg);
    check("model_we", wb_we, e_we);
    check("model_rd", wb_rd, e_rd);
    check("model_data", wb_data, e_data);
    check("model_fp", wb_fp, e_fp);
    check("model_nc", no_collision, e_nc);
    check("model_stall", stall_cycles, 64'(m_stall));
  end

  always @(posedge clk) begin
    m_wait[0] <= n_wait[0];
    m_wait[1] <= n_wait[1];
    m_drain   <= n_drain;
    m_rr      <= n_rr;
    m_stall   <= n_stall;
  end

  task automatic next_cycle();
    @(posedge clk); #2;
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; pipe_wb_valid = 1'b0; mc_req_valid = 2'b00;
    next_cycle();
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [1:0] exp_g;
    reset_n = 1'b0;
    pipe_wb_valid = 1'b1; pipe_wb_rd = 5'd7; pipe_wb_data = 32'h1234_5678; pipe_wb_fp = 1'b0;
    mc_req_valid = 2'b11; mc_req_rd = {5'd9, 5'd5};
    mc_req_data = {32'hCAFE_F00D, 32'hDEAD_BEEF}; mc_req_fp = 2'b10;

    // Reset held two cycles with every input active
    settle();
    check("rst_we", wb_we, 0); check("rst_ready", mc_req_ready, 0); check("rst_nc", no_collision, 1);
    next_cycle();
    settle();
    check("rst_we2", wb_we, 0); check("rst_ready2", mc_req_ready, 0);
    check("rst_nc2", no_collision, 1); check("rst_stall", stall_cycles, 0);
    next_cycle();

    // Idle slot goes to the lone valid unit in the same cycle
    reset_n = 1'b1; pipe_wb_valid = 1'b0; mc_req_valid = 2'b01;
    settle();
    check("idle_ready", mc_req_ready, 2'b01); check("idle_we", wb_we, 1);
    check("idle_rd", wb_rd, 5); check("idle_data", wb_data, 32'hDEAD_BEEF);
    next_cycle();
    mc_req_valid = 2'b00;
    next_cycle();

    // Round-robin with both units valid
    do_reset();
    mc_req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
      settle();
      exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
      check("rr_grant", mc_req_ready, exp_g);
      next_cycle();
    end
    mc_req_valid = 2'b00;
    next_cycle();

    // Single-unit starvation under a busy pipeline
    do_reset();
    pipe_wb_valid = 1'b1; mc_req_valid = 2'b10;
    for (int k = 0; k < 12; k++) begin
      settle();
      if (k == 8) check("starve_nc_k8", no_collision, 1);
      if (k == 9) check("starve_nc_k9", no_collision, 0);
      if (k == 11) begin
        check("starve_pipe_ready", mc_req_ready, 2'b00);
        check("starve_pipe_rd", wb_rd, 7);
      end
      next_cycle();
    end
    pipe_wb_valid = 1'b0;
    settle();
    check("starve_grant", mc_req_ready, 2'b10); check("starve_rd", wb_rd, 9);
    check("starve_nc_grant", no_collision, 0);
    next_cycle();
    mc_req_valid = 2'b00;
    settle();
    check("starve_nc_back", no_collision, 1); check("starve_stall", stall_cycles, 4);
    next_cycle();

    // Both units starve together: one DRAIN episode serves both
    do_reset();
    pipe_wb_valid = 1'b1; mc_req_valid = 2'b11;
    for (int k = 0; k < 10; k++) begin
      settle();
      if (k == 9) check("dbl_nc_k9", no_collision, 0);
      next_cycle();
    end
    pipe_wb_valid = 1'b0;
    settle();
    check("dbl_grant0", mc_req_ready, 2'b01);
    next_cycle();
    mc_req_valid = 2'b10;
    settle();
    check("dbl_grant1", mc_req_ready, 2'b10); check("dbl_nc_mid", no_collision, 0);
    next_cycle();
    mc_req_valid = 2'b00;
    settle();
    check("dbl_nc_back", no_collision, 1); check("dbl_stall", stall_cycles, 3);
    next_cycle();

    // Reset while stalled
    do_reset();
    pipe_wb_valid = 1'b1; mc_req_valid = 2'b01;
    for (int k = 0; k < 11; k++) begin
      settle();
      if (k == 10) check("rstd_nc_drain", no_collision, 0);
      next_cycle();
    end
    reset_n = 1'b0; pipe_wb_valid = 1'b0;
    settle();
    check("rstd_ready", mc_req_ready, 2'b00); check("rstd_we", wb_we, 0);
    check("rstd_nc", no_collision, 1);
    next_cycle();
    reset_n = 1'b1; pipe_wb_valid = 1'b1;
    settle();
    check("rstd_nc_after", no_collision, 1); check("rstd_stall", stall_cycles, 0);
    next_cycle();
    pipe_wb_valid = 1'b0; mc_req_valid = 2'b00;
    next_cycle();
    next_cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
